sqrt_cordic: RTL and testbench
==============================

SQRT_CORDIC -- requirements
Module: sqrt_cordic

Interface
REQ-001 SHALL have parameter DATA_W, default 22, meaning unsigned operand/result width.
REQ-002 SHALL have parameter FRAC_W, default 8, meaning fractional bits of i_W and o_Q (even, < DATA_W).
REQ-003 SHALL have parameter ITER, default 12, meaning hyperbolic iteration indices 1..ITER (4..20).
REQ-004 SHALL have port i_clock, input, 1, meaning the single clock; all state updates on rising edge.
REQ-005 SHALL have port i_Reset_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port i_start, input, 1, meaning request; sampled only in IDLE.
REQ-007 SHALL have port i_W, input, DATA_W, meaning unsigned radicand; captured on an accepted i_start.
REQ-008 SHALL have port o_busy, output, 1, meaning high in every state except IDLE.
REQ-009 SHALL have port o_valid, output, 1, meaning one-cycle pulse: o_Q updated this cycle.
REQ-010 SHALL have port o_Q, output, DATA_W, meaning unsigned sqrt(i_W), same format; held until next o_valid.

Function
REQ-011 SHALL implement FSM IDLE -> NORM -> ITERATE -> COMP -> DONE -> IDLE; one cycle each except ITERATE.
REQ-012 IDLE SHALL move to NORM on i_start=1, latching i_W; i_start otherwise ignored, including while o_busy=1.
REQ-013 NORM SHALL find even shift 2e (signed e) so m = W/4^e lies in [0.25,1), then load x=m+0.25, y=m-0.25.
REQ-014 Datapath x,y SHALL be signed, DATA_W+4 bits, at least FRAC_W+2 fractional bits; shifts arithmetic.
REQ-015 ITERATE SHALL run shift sequence 1..ITER with indices 4 and 13 (when <= ITER) executed twice; N_EFF = ITER + repeats (default 13 cycles).
REQ-016 Per step, y<0: x<=x+(y>>>i), y<=y+(x>>>i); y>=0: x<=x-(y>>>i), y<=y-(x>>>i); both from pre-step values.
REQ-017 COMP SHALL multiply x by constant 1/K_h for the executed sequence, shift by e, and round to nearest to FRAC_W bits.
REQ-018 COMP results exceeding 2^DATA_W-1 SHALL saturate to all ones.
REQ-019 i_W=0 SHALL bypass normalisation and produce o_Q=0 with unchanged latency.
REQ-020 DONE SHALL update o_Q and pulse o_valid for exactly one cycle; o_busy drops in the following cycle.
REQ-021 Latency SHALL be N_EFF+4 rising edges from the edge sampling i_start to the edge raising o_valid (default 17); the next i_start is accepted in the cycle after DONE.
REQ-022 Error SHALL be <= 2 LSB of o_Q over the full input range for default parameters.

Reset
REQ-023 i_Reset_n=0 SHALL asynchronously force IDLE, o_busy=0, o_valid=0, o_Q=0, counters and datapath 0.
REQ-024 Reset mid-operation SHALL abort the computation with no o_valid pulse; after release the block accepts i_start normally.
REQ-025 Reset release SHALL be synchronised by the instantiating context; no internal synchroniser.

Structure
REQ-026 Package sqrt_cordic_pkg SHALL hold the FSM state enum, the repeat-index constants (4, 13), and a function giving 1/K_h in fixed point for ITER.
REQ-027 Normalisation SHALL be sub-module sqrt_norm (combinational leading-zero count rounded to even shift, outputs m and e).
REQ-028 Iteration counter and repeat flag SHALL be explicit registers; no per-iteration unrolled hardware.

Verification
REQ-029 Reset, i_W=2304 (9.0), pulse i_start -> o_valid exactly 17 edges later, o_Q in 766..770 (3.0).
REQ-030 i_W=512 (2.0) -> o_Q in 360..364; i_W=64 (0.25) -> o_Q in 126..130.
REQ-031 i_W=0 -> o_Q=0 at 17 cycles; i_W=4194303 -> o_Q in 32765..32767, no wrap.
REQ-032 i_start pulsed again 5 cycles after first start, different i_W -> ignored; single o_valid with first result.
REQ-033 i_Reset_n low at cycle 8 of a computation -> outputs 0 immediately, no o_valid; new start then completes correctly.
REQ-034 Back-to-back starts for i_W=k^2*256, k=1..60 -> each o_Q within 2 LSB of k*256; o_busy low exactly one cycle between runs.

Source files
------------

// File: rtl/sqrt_cordic_pkg.sv
// Shared types and constants for the hyperbolic CORDIC square root.
// inv_kh() is evaluated at elaboration to give the gain correction constant.
package sqrt_cordic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        NORM,
        ITERATE,
        COMP,
        DONE
    } state_t;

    localparam int unsigned REPEAT_A = 4;
    localparam int unsigned REPEAT_B = 13;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned IDX_W    = 5;

    // K^2 = prod(1 - 2^-2i) in Q.60, K = isqrt(K^2) in Q.30, result = round(2^frac / K).
    function automatic logic [63:0] inv_kh(input int unsigned iter, input int unsigned frac);
        logic [63:0]  k2;
        logic [63:0]  rem;
        logic [63:0]  root;
        logic [63:0]  bitv;
        logic [127:0] num;
        k2 = 64'd1 << 60;
        for (int unsigned i = 1; i <= iter; i++) begin
            k2 = k2 - (k2 >> (2 * i));
            if (i == REPEAT_A || i == REPEAT_B)
                k2 = k2 - (k2 >> (2 * i));
        end
        rem  = k2;
        root = '0;
        for (int unsigned b = 0; b < 32; b++) begin
            bitv = 64'd1 << (62 - 2 * b);
            if (rem >= root + bitv) begin
                rem  = rem - (root + bitv);
                root = (root >> 1) + bitv;
            end else begin
                root = root >> 1;
            end
        end
        num = (128'd1 << (frac + 30)) + 128'(root >> 1);
        return 64'(num / 128'(root));
    endfunction

endpackage

// File: rtl/sqrt_cordic_norm.sv
// Normaliser: shifts the radicand left by an even amount so its mantissa lies in [0.25,1)
// and reports the matching exponent e (value = m * 4^e in the input's fixed-point format).
module sqrt_norm
    import sqrt_cordic_pkg::*;
#(
    parameter int unsigned DATA_W = 22,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned NW     = 22
) (
    input  logic [DATA_W-1:0]       w,
    output logic [NW-1:0]           m,
    output logic signed [EXP_W-1:0] e
);

    logic [EXP_W-1:0] msb;
    logic [EXP_W-1:0] lz;
    logic [EXP_W-1:0] shift;
    logic [EXP_W-1:0] half;

    always_comb begin
        msb = '0;
        for (int unsigned i = 0; i < DATA_W; i++)
            if (w[i]) msb = EXP_W'(i);
        lz    = EXP_W'(NW - 1) - msb;
        shift = lz & ~EXP_W'(1);
        half  = shift >> 1;
        m     = NW'(w) << shift;
        e     = $signed(EXP_W'((NW - FRAC_W) / 2)) - $signed(half);
    end

endmodule

// File: rtl/sqrt_cordic.sv
// Iterative hyperbolic-vectoring CORDIC square root of an unsigned fixed-point operand.
// One micro-rotation per cycle; gain correction, rescaling and rounding in COMP.
module sqrt_cordic
    import sqrt_cordic_pkg::*;
#(
    parameter int unsigned DATA_W = 22,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned ITER   = 12
) (
    input  logic              i_clock,
    input  logic              i_Reset_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_W,
    output logic              o_busy,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_Q
);

    localparam int unsigned NW = DATA_W + (DATA_W % 2);
    localparam int unsigned XW = DATA_W + 4;
    localparam int unsigned FB = XW - 3;
    localparam int unsigned CW = FB + 2;
    localparam int unsigned PW = XW - 1 + CW;
    localparam int unsigned QB = (NW + FRAC_W) / 2;

    localparam logic [CW-1:0]        INV_KH   = CW'(inv_kh(ITER, FB));
    localparam logic signed [XW-1:0] QUARTER  = XW'(1) << (FB - 2);
    localparam logic [PW:0]          ALL_ONES = (PW + 1)'({DATA_W{1'b1}});
    localparam logic [PW:0]          QMAX     = ((PW + 1)'(1) << QB) - (PW + 1)'(1);

    state_t                   state;
    logic [DATA_W-1:0]        w_reg;
    logic [NW-1:0]            m_reg;
    logic signed [EXP_W-1:0]  e_reg;
    logic                     zero_reg;
    logic signed [XW-1:0]     x;
    logic signed [XW-1:0]     y;
    logic [IDX_W-1:0]         idx;
    logic                     rep_flag;
    logic [DATA_W-1:0]        q_res;

    logic [NW-1:0]            norm_m;
    logic signed [EXP_W-1:0]  norm_e;
    logic signed [XW-1:0]     m_fix;
    logic signed [XW-1:0]     x_sh;
    logic signed [XW-1:0]     y_sh;
    logic signed [XW-1:0]     x_nx;
    logic signed [XW-1:0]     y_nx;
    logic                     repeat_now;
    logic [XW-2:0]            x_pos;
    logic [PW-1:0]            prod;
    logic [EXP_W-1:0]         sh;
    logic [PW:0]              rounded;
    logic [PW:0]              q_wide;
    logic [DATA_W-1:0]        comp_q;

    sqrt_norm #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .NW     (NW)
    ) u_norm (
        .w (w_reg),
        .m (norm_m),
        .e (norm_e)
    );

    always_comb begin
        m_fix = $signed(XW'(m_reg) << (FB - NW));
        x_sh  = x >>> idx;
        y_sh  = y >>> idx;
        if (y[XW-1]) begin
            x_nx = x + y_sh;
            y_nx = y + x_sh;
        end else begin
            x_nx = x - y_sh;
            y_nx = y - x_sh;
        end
        repeat_now = (idx == IDX_W'(REPEAT_A) || idx == IDX_W'(REPEAT_B)) && !rep_flag;
    end

    // Any true root lies below 2^QB, so a result at or above it is round-up overshoot.
    always_comb begin
        x_pos   = x[XW-1] ? '0 : x[XW-2:0];
        prod    = PW'(x_pos) * PW'(INV_KH);
        sh      = EXP_W'(2 * FB - FRAC_W) - e_reg;
        rounded = {1'b0, prod} + ((PW + 1)'(1) << (sh - EXP_W'(1)));
        q_wide  = rounded >> sh;
        if (zero_reg)
            comp_q = '0;
        else if (q_wide > ALL_ONES)
            comp_q = '1;
        else if (q_wide > QMAX)
            comp_q = DATA_W'(QMAX);
        else
            comp_q = DATA_W'(q_wide);
    end

    // idx == 0 in ITERATE is the x/y load cycle; micro-rotations use idx 1..ITER.
    always_ff @(posedge i_clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state    <= IDLE;
            w_reg    <= '0;
            m_reg    <= '0;
            e_reg    <= '0;
            zero_reg <= 1'b0;
            x        <= '0;
            y        <= '0;
            idx      <= '0;
            rep_flag <= 1'b0;
            q_res    <= '0;
            o_busy   <= 1'b0;
            o_valid  <= 1'b0;
            o_Q      <= '0;
        end else begin
            o_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        w_reg  <= i_W;
                        o_busy <= 1'b1;
                        state  <= NORM;
                    end
                end
                NORM: begin
                    m_reg    <= norm_m;
                    e_reg    <= norm_e;
                    zero_reg <= (w_reg == '0);
                    idx      <= '0;
                    rep_flag <= 1'b0;
                    state    <= ITERATE;
                end
                ITERATE: begin
                    if (idx == '0) begin
                        x   <= m_fix + QUARTER;
                        y   <= m_fix - QUARTER;
                        idx <= IDX_W'(1);
                    end else begin
                        x <= x_nx;
                        y <= y_nx;
                        if (repeat_now) begin
                            rep_flag <= 1'b1;
                        end else begin
                            rep_flag <= 1'b0;
                            if (idx == IDX_W'(ITER))
                                state <= COMP;
                            else
                                idx <= idx + IDX_W'(1);
                        end
                    end
                end
                COMP: begin
                    q_res <= comp_q;
                    state <= DONE;
                end
                DONE: begin
                    o_Q     <= q_res;
                    o_valid <= 1'b1;
                    o_busy  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_cordic.sv
// Scoreboard bench for sqrt_cordic: stimulus pushes expected result windows,
// a negedge monitor pops and checks value and latency on every o_valid.
module tb_sqrt_cordic;

    localparam int DATA_W  = 22;
    localparam int LATENCY = 17;

    typedef struct {
        int lo;
        int hi;
        int start_cyc;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [DATA_W-1:0] w;
    logic              busy;
    logic              valid;
    logic [DATA_W-1:0] q;

    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    exp_t sb[$];

    sqrt_cordic #(
        .DATA_W (22),
        .FRAC_W (8),
        .ITER   (12)
    ) dut (
        .i_clock   (clk),
        .i_Reset_n (rst_n),
        .i_start   (start),
        .i_W       (w),
        .o_busy    (busy),
        .o_valid   (valid),
        .o_Q       (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: actual=%0d required=%0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    // Reference: o_Q = sqrt(W/256)*256 = 16*sqrt(W), accepted within 2 LSB.
    function automatic exp_t model(input int unsigned wv);
        exp_t e;
        real  r;
        r = $sqrt(real'(wv)) * 16.0;
        e.lo = (wv == 0) ? 0 : $rtoi($ceil(r - 2.0));
        e.hi = (wv == 0) ? 0 : $rtoi($floor(r + 2.0));
        if (e.lo < 0) e.lo = 0;
        e.start_cyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", int'(q), -1, -1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", int'(q), e.lo, e.hi);
                chk("latency", cyc - e.start_cyc, LATENCY, LATENCY);
                chk("busy_with_valid", int'(busy), 0, 0);
            end
        end
    end

    task automatic issue(input int unsigned wv, input int lo, input int hi, output int accepted_cyc);
        exp_t e;
        int   n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", int'(busy), 0, 0);
        accepted_cyc = cyc + 1;
        if (busy) return;
        w     = DATA_W'(wv);
        start = 1'b1;
        e.lo = lo;
        e.hi = hi;
        e.start_cyc = accepted_cyc;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1, 1);
    endtask

    task automatic issue_model(input int unsigned wv);
        exp_t e;
        int   c;
        e = model(wv);
        issue(wv, e.lo, e.hi, c);
    endtask

    initial begin
        int c;
        int prev;
        rst_n = 1'b0;
        start = 1'b0;
        w     = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0, 0);
        chk("reset_valid", int'(valid), 0, 0);
        chk("reset_q", int'(q), 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(2304, 766, 770, c);
        issue(512, 360, 364, c);
        issue(64, 126, 130, c);
        issue(0, 0, 0, c);
        issue(4194303, 32765, 32767, c);
        issue_model(1);
        issue_model(3);
        issue_model(255);

        issue(2304, 766, 770, c);
        repeat (4) @(negedge clk);
        w     = DATA_W'(512);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        for (int i = 0; i < 40; i++)
            issue_model($urandom_range(0, 4194303));

        issue(2304, 766, 770, c);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", int'(busy), 0, 0);
        chk("midreset_valid", int'(valid), 0, 0);
        chk("midreset_q", int'(q), 0, 0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        issue(512, 360, 364, c);

        prev = -1;
        for (int k = 1; k <= 60; k++) begin
            issue(k * k * 256, k * 256 - 2, k * 256 + 2, c);
            if (prev >= 0) chk("b2b_gap", c - prev, LATENCY + 1, LATENCY + 1);
            prev = c;
        end

        for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
        chk("drain", sb.size(), 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached with %0d results outstanding", sb.size());
        $fatal(1, "watchdog");
    end

endmodule
